// File: rtl/tcp_reassembly_buffer.sv
// tcp_reassembly_buffer: stores TCP payload bytes by sequence number and releases them in order
module tcp_reassembly_buffer #(
    parameter int BYTES_PER_BEAT = 2,
    parameter int DEPTH          = 64,
    parameter int SEQ_BITS       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEQ_BITS-1:0]         base_seq,
    input  logic                        base_load,
    input  logic [8*BYTES_PER_BEAT-1:0] s_axis_tdata,
    input  logic [BYTES_PER_BEAT-1:0]   s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [SEQ_BITS-1:0]         s_seq,
    output logic [8*BYTES_PER_BEAT-1:0] m_axis_tdata,
    output logic [BYTES_PER_BEAT-1:0]   m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [SEQ_BITS-1:0]         ack_seq,
    output logic                        ack_update,
    output logic [15:0]                 window_size,
    output logic [15:0]                 drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BYTES_PER_BEAT + 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [DEPTH-1:0]            valid;
    logic [7:0]                  mem [DEPTH];
    logic [SEQ_BITS-1:0]         rd_seq;
    logic [AW:0]                 occupied;
    logic                        hs, load, cont;
    logic [BYTES_PER_BEAT-1:0]   wr_en, take;
    logic [SEQ_BITS-1:0]         off [BYTES_PER_BEAT];
    logic [AW-1:0]               wr_slot [BYTES_PER_BEAT];
    logic [AW-1:0]               rd_slot [BYTES_PER_BEAT];
    logic [CW-1:0]               wr_n, drop_n, rd_n;
    logic [8*BYTES_PER_BEAT-1:0] tdata_nx;
    logic [16:0]                 drop_sum;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // a (re)anchor always enters RUN; nothing else leaves a state
    always_comb state_nx = base_load ? RUN : state;

    // input is accepted only while running
    always_comb s_axis_tready = (state == RUN);

    // per-lane window classification and in-order contiguity scan over registered valid bits
    always_comb begin
        hs       = s_axis_tvalid && s_axis_tready && !base_load;
        load     = !m_axis_tvalid || m_axis_tready;
        wr_en    = '0;
        take     = '0;
        wr_n     = '0;
        drop_n   = '0;
        rd_n     = '0;
        tdata_nx = '0;
        cont     = load && !base_load;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            off[i]     = s_seq + SEQ_BITS'(i) - rd_seq;
            wr_slot[i] = AW'(s_seq + SEQ_BITS'(i));
            rd_slot[i] = AW'(rd_seq + SEQ_BITS'(i));
            if (hs && s_axis_tkeep[i]) begin
                if (off[i] >= SEQ_BITS'(DEPTH)) drop_n = drop_n + CW'(1);
                else if (!valid[wr_slot[i]]) begin
                    wr_en[i] = 1'b1;
                    wr_n     = wr_n + CW'(1);
                end
            end
            cont    = cont && valid[rd_slot[i]];
            take[i] = cont;
            if (cont) begin
                rd_n              = rd_n + CW'(1);
                tdata_nx[8*i +: 8] = mem[rd_slot[i]];
            end
        end
        drop_sum = {1'b0, drop_count} + 17'(drop_n);
    end

    // byte storage; only invalid slots are ever written
    always_ff @(posedge clk)
        for (int i = 0; i < BYTES_PER_BEAT; i++)
            if (wr_en[i]) mem[wr_slot[i]] <= s_axis_tdata[8*i +: 8];

    // slot valid bits, read pointer, occupancy, drop counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid         <= '0;
            rd_seq        <= '0;
            occupied      <= '0;
            drop_count    <= '0;
            ack_update    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
        end else if (base_load) begin
            valid         <= '0;
            rd_seq        <= base_seq;
            occupied      <= '0;
            ack_update    <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            for (int i = 0; i < BYTES_PER_BEAT; i++) begin
                if (wr_en[i]) valid[wr_slot[i]] <= 1'b1;
                if (take[i])  valid[rd_slot[i]] <= 1'b0;
            end
            rd_seq     <= rd_seq + SEQ_BITS'(rd_n);
            occupied   <= occupied + (AW+1)'(wr_n) - (AW+1)'(rd_n);
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ack_update <= (rd_n != '0);
            if (load) begin
                m_axis_tvalid <= (rd_n != '0);
                m_axis_tkeep  <= take;
                m_axis_tdata  <= tdata_nx;
            end
        end
    end

    assign ack_seq     = rd_seq;
    assign window_size = 16'(DEPTH) - 16'(occupied);
endmodule

// File: tb/tb_tcp_reassembly_buffer.sv
// tb_tcp_reassembly_buffer: directed self-checking bench for tcp_reassembly_buffer (2 bytes/beat, 16 slots)
module tb_tcp_reassembly_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] base_seq = '0;
    logic        base_load = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic [1:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_seq = '0;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] ack_seq;
    logic        ack_update;
    logic [15:0] window_size;
    logic [15:0] drop_count;
    int total = 0;
    int bad = 0;

    tcp_reassembly_buffer #(.BYTES_PER_BEAT(2), .DEPTH(16), .SEQ_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .base_seq(base_seq), .base_load(base_load),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_seq(s_seq),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .ack_seq(ack_seq), .ack_update(ack_update),
        .window_size(window_size), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic anchor(input logic [31:0] seq);
        base_seq  = seq;
        base_load = 1'b1;
        tick();
        base_load = 1'b0;
    endtask

    task automatic send(input logic [31:0] seq, input logic [15:0] data, input logic [1:0] keep);
        s_seq         = seq;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tkeep  = '0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_mvalid", 32'(m_axis_tvalid), 0);
        chk("rst_ack", ack_seq, 0);
        chk("rst_ackupd", 32'(ack_update), 0);
        chk("rst_window", 32'(window_size), 16);
        chk("rst_drop", 32'(drop_count), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_tready", 32'(s_axis_tready), 0);

        anchor(1000);
        chk("run_tready", 32'(s_axis_tready), 1);
        chk("anchor_ack", ack_seq, 1000);
        send(1000, 16'hAABB, 2'b11);
        chk("inord_win14", 32'(window_size), 14);
        chk("inord_notyet", 32'(m_axis_tvalid), 0);
        tick();
        chk("inord_valid", 32'(m_axis_tvalid), 1);
        chk("inord_data", 32'(m_axis_tdata), 32'hAABB);
        chk("inord_keep", 32'(m_axis_tkeep), 2'b11);
        chk("inord_ack", ack_seq, 1002);
        chk("inord_ackupd", 32'(ack_update), 1);
        chk("inord_win16", 32'(window_size), 16);
        tick();
        chk("inord_ackupd_off", 32'(ack_update), 0);
        chk("inord_idle", 32'(m_axis_tvalid), 0);

        anchor(1000);
        send(1002, 16'h3344, 2'b11);
        chk("ooo_win14", 32'(window_size), 14);
        chk("ooo_ack", ack_seq, 1000);
        tick();
        chk("ooo_hold", 32'(m_axis_tvalid), 0);
        send(1000, 16'h1122, 2'b11);
        tick();
        chk("ooo_b0_data", 32'(m_axis_tdata), 32'h1122);
        chk("ooo_b0_ack", ack_seq, 1002);
        tick();
        chk("ooo_b1_valid", 32'(m_axis_tvalid), 1);
        chk("ooo_b1_data", 32'(m_axis_tdata), 32'h3344);
        chk("ooo_b1_ack", ack_seq, 1004);
        tick();
        chk("ooo_empty", 32'(m_axis_tvalid), 0);
        chk("ooo_win16", 32'(window_size), 16);

        anchor(1000);
        send(1001, 16'h0011, 2'b01);
        chk("mis_win15", 32'(window_size), 15);
        send(1000, 16'h0010, 2'b01);
        tick();
        chk("mis_data", 32'(m_axis_tdata), 32'h1110);
        chk("mis_keep", 32'(m_axis_tkeep), 2'b11);
        send(1002, 16'h0055, 2'b01);
        tick();
        chk("lone_valid", 32'(m_axis_tvalid), 1);
        chk("lone_keep", 32'(m_axis_tkeep), 2'b01);
        chk("lone_byte", 32'(m_axis_tdata[7:0]), 32'h55);
        chk("lone_ack", ack_seq, 1003);

        anchor(1000);
        send(1016, 16'hEEEE, 2'b11);
        chk("drop_future", 32'(drop_count), 2);
        chk("drop_win", 32'(window_size), 16);
        send(998, 16'h00EE, 2'b01);
        chk("drop_old", 32'(drop_count), 3);
        send(1001, 16'h0077, 2'b01);
        send(1001, 16'h0099, 2'b01);
        chk("dup_drop", 32'(drop_count), 3);
        chk("dup_win", 32'(window_size), 15);
        send(1000, 16'h0066, 2'b01);
        tick();
        chk("dup_data", 32'(m_axis_tdata), 32'h7766);

        anchor(1000);
        m_axis_tready = 1'b0;
        for (int k = 0; k < 9; k++)
            send(32'(1000 + 2*k), {8'(8'h41 + 2*k), 8'(8'h40 + 2*k)}, 2'b11);
        chk("full_win0", 32'(window_size), 0);
        chk("full_valid", 32'(m_axis_tvalid), 1);
        chk("full_hold", 32'(m_axis_tdata), 32'h4140);
        chk("full_ack", ack_seq, 1002);
        send(1018, 16'hDEAD, 2'b11);
        chk("full_drop", 32'(drop_count), 5);
        chk("full_stable", 32'(m_axis_tdata), 32'h4140);
        m_axis_tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("drain_data%0d", k), 32'(m_axis_tdata), 32'({8'(8'h41 + 2*k), 8'(8'h40 + 2*k)}));
            tick();
        end
        chk("drain_empty", 32'(m_axis_tvalid), 0);
        chk("drain_win16", 32'(window_size), 16);
        chk("drain_ack", ack_seq, 1018);

        anchor(32'hFFFF_FFFE);
        send(32'hFFFF_FFFE, 16'hA2A1, 2'b11);
        send(32'h0000_0000, 16'hB2B1, 2'b11);
        chk("wrap_b0", 32'(m_axis_tdata), 32'hA2A1);
        chk("wrap_ack0", ack_seq, 0);
        tick();
        chk("wrap_b1", 32'(m_axis_tdata), 32'hB2B1);
        chk("wrap_ack2", ack_seq, 2);
        tick();
        chk("wrap_win16", 32'(window_size), 16);

        send(32'h0000_0005, 16'h1234, 2'b11);
        chk("pre_rst_win", 32'(window_size), 14);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_win", 32'(window_size), 16);
        chk("midrst_tready", 32'(s_axis_tready), 0);
        chk("midrst_drop", 32'(drop_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
